// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first, one bit
// per TICK_DIV clocks, with a per-bit strobe, optional gapless repeat and abort.
module seq_pattern_tx #(
    parameter int MAX_LEN  = 8,
    parameter int LEN_BITS = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [MAX_LEN-1:0]  pattern_i,
    input  logic [LEN_BITS-1:0] length_i,
    input  logic                repeat_en_i,
    input  logic                abort_i,
    output logic                w_out_o,
    output logic                bit_strobe_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          state_o
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);
    localparam logic [LEN_BITS-1:0] ONE_L     = LEN_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [MAX_LEN-1:0]    shreg_q, shreg_d;
    logic [MAX_LEN-1:0]    cap_pat_q, cap_pat_d;
    logic [LEN_BITS-1:0]   cap_len_q, cap_len_d;
    logic [LEN_BITS-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [MAX_LEN-1:0]    loaded;
    logic                  tick;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cap_pat_q <= '0;
            cap_len_q <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cap_pat_q <= cap_pat_d;
            cap_len_q <= cap_len_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
        end
    end

    // Left-align the captured pattern so its first bit sits at the MSB.
    assign loaded = cap_pat_q << (MAX_LEN_L - cap_len_q);
    assign tick   = (div_q == DIV_LAST);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cap_pat_d    = cap_pat_q;
        cap_len_d    = cap_len_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        w_out_o      = 1'b0;
        bit_strobe_o = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && (length_i != '0)) begin
                    cap_pat_d = pattern_i;
                    cap_len_d = (length_i > MAX_LEN_L) ? MAX_LEN_L : length_i;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                shreg_d = loaded;
                cnt_d   = cap_len_q;
                div_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                w_out_o = shreg_q[MAX_LEN-1];
                if (tick) begin
                    bit_strobe_o = 1'b1;
                    div_d        = '0;
                    if (cnt_q == ONE_L) begin
                        if (repeat_en_i) begin
                            shreg_d = loaded;
                            cnt_d   = cap_len_q;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q - ONE_L;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Cancel wins over everything, including a strobe or done in this cycle.
        if (abort_i) begin
            state_d      = IDLE;
            bit_strobe_o = 1'b0;
            done_o       = 1'b0;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance at TICK_DIV=1 and one at
// TICK_DIV=3 share stimulus; serial bits are checked against a scoreboard queue.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] length;
    logic       repeat_en;
    logic       abort;

    logic       w_a, strobe_a, busy_a, done_a;
    logic [1:0] state_a;
    logic       w_b, strobe_b, busy_b, done_b;
    logic [1:0] state_b;

    int checks   = 0;
    int failures = 0;
    int nstrobe_a;
    bit chk_a = 1'b1;
    bit chk_b = 1'b0;
    logic q_a[$];
    logic q_b[$];

    always #5 clk = ~clk;

    seq_pattern_tx #(.MAX_LEN(8), .LEN_BITS(4), .TICK_DIV(1)) dut_a (
        .clock_i(clk), .reset_i(reset), .start_i(start), .pattern_i(pattern),
        .length_i(length), .repeat_en_i(repeat_en), .abort_i(abort),
        .w_out_o(w_a), .bit_strobe_o(strobe_a), .busy_o(busy_a),
        .done_o(done_a), .state_o(state_a)
    );

    seq_pattern_tx #(.MAX_LEN(8), .LEN_BITS(4), .TICK_DIV(3)) dut_b (
        .clock_i(clk), .reset_i(reset), .start_i(start), .pattern_i(pattern),
        .length_i(length), .repeat_en_i(repeat_en), .abort_i(abort),
        .w_out_o(w_b), .bit_strobe_o(strobe_b), .busy_o(busy_b),
        .done_o(done_b), .state_o(state_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any strobed bit.
    task automatic step();
        logic e;
        @(negedge clk);
        if (chk_a && strobe_a) begin
            nstrobe_a++;
            if (q_a.size() == 0) check("extra_strobe_a", 32'd1, 32'd0);
            else begin
                e = q_a.pop_front();
                check("w_a_bit", {31'd0, w_a}, {31'd0, e});
            end
        end
        if (chk_b && strobe_b) begin
            if (q_b.size() == 0) check("extra_strobe_b", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                check("w_b_bit", {31'd0, w_b}, {31'd0, e});
            end
        end
    endtask

    task automatic run_pass(input logic [7:0] pat, input logic [3:0] len);
        int eff;
        eff = (len > 4'd8) ? 8 : int'(len);
        for (int i = eff - 1; i >= 0; i--) q_a.push_back(pat[i]);
        pattern = pat;
        length  = len;
        start   = 1'b1;
        step();
        start     = 1'b0;
        nstrobe_a = 0;
        check("pass_load_state", {30'd0, state_a}, 32'd1);
        repeat (eff) step();
        check("pass_strobes", nstrobe_a, eff);
        step();
        check("pass_done", {31'd0, done_a}, 32'd1);
        step();
        check("pass_idle_busy", {31'd0, busy_a}, 32'd0);
        check("pass_queue_empty", q_a.size(), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pattern   = '0;
        length    = '0;
        repeat_en = 1'b0;
        abort     = 1'b0;
        #3;
        check("rst_w", {31'd0, w_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_state", {30'd0, state_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // 1: 1101 at one bit per clock
        run_pass(8'h0D, 4'd4);

        // 2: repeat of 111, dropped during the third pass
        for (int i = 0; i < 9; i++) q_a.push_back(1'b1);
        pattern   = 8'h07;
        length    = 4'd3;
        repeat_en = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        nstrobe_a = 0;
        repeat (7) step();
        repeat_en = 1'b0;
        repeat (2) step();
        check("rep_strobes_no_gap", nstrobe_a, 32'd9);
        step();
        check("rep_done", {31'd0, done_a}, 32'd1);
        step();
        check("rep_idle", {31'd0, busy_a}, 32'd0);
        check("rep_queue_empty", q_a.size(), 32'd0);

        // 3: abort on the second bit of AA
        q_a.push_back(1'b1);
        q_a.push_back(1'b0);
        pattern = 8'hAA;
        length  = 4'd8;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", {30'd0, state_a}, 32'd0);
        check("abort_w", {31'd0, w_a}, 32'd0);
        check("abort_done", {31'd0, done_a}, 32'd0);
        step();
        check("abort_no_done_later", {31'd0, done_a}, 32'd0);
        check("abort_queue_empty", q_a.size(), 32'd0);
        run_pass(8'h05, 4'd3);

        // 4: zero length ignored, oversize length clamped
        pattern = 8'hFF;
        length  = 4'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("len0_busy", {31'd0, busy_a}, 32'd0);
        step();
        check("len0_busy_later", {31'd0, busy_a}, 32'd0);
        run_pass(8'hB4, 4'd12);

        // 5: three clocks per bit on the second instance
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk_a = 1'b0;
        chk_b = 1'b1;
        q_b.push_back(1'b1);
        q_b.push_back(1'b0);
        pattern = 8'h02;
        length  = 4'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("div3_w", {31'd0, w_b}, (c <= 3) ? 32'd1 : 32'd0);
            check("div3_strobe", {31'd0, strobe_b}, (c == 3 || c == 6) ? 32'd1 : 32'd0);
        end
        step();
        check("div3_done", {31'd0, done_b}, 32'd1);
        step();
        check("div3_idle", {31'd0, busy_b}, 32'd0);
        check("div3_queue_empty", q_b.size(), 32'd0);
        chk_b = 1'b0;

        // 6: asynchronous reset mid-shift
        pattern = 8'hFF;
        length  = 4'd8;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_state", {30'd0, state_a}, 32'd2);
        check("pre_rst_w", {31'd0, w_a}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_w", {31'd0, w_a}, 32'd0);
        check("arst_strobe", {31'd0, strobe_a}, 32'd0);
        check("arst_busy", {31'd0, busy_a}, 32'd0);
        check("arst_state", {30'd0, state_a}, 32'd0);
        #1 reset = 1'b0;
        step();
        step();
        check("post_rst_state", {30'd0, state_a}, 32'd0);
        check("post_rst_w", {31'd0, w_a}, 32'd0);
        chk_a = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
